// File: rtl/pipe_reg_chain_pkg.sv
// Shared defaults and sizing helpers for the valid/ready register chain.
package pipe_reg_chain_pkg;

  localparam int DEF_WIDTH     = 3;
  localparam int DEF_STAGES    = 2;
  localparam int DEF_RESET_VAL = 0;

  // Bits needed to count 0..stages occupied slots.
  function automatic int count_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One data+valid slot of the chain; ready passes through when the slot is empty
// or its content is leaving this cycle.
import pipe_reg_chain_pkg::*;

module pipe_reg_stage #(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_up_valid,
  input  logic [WIDTH-1:0] i_up_data,
  input  logic             i_dn_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_ready
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_load;

  assign o_ready = !r_valid || i_dn_ready;
  // Data is frozen during flush so only the valid bits are affected.
  assign w_load  = i_up_valid && o_ready && !i_flush;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Slot occupancy: refilled or emptied whenever the slot can move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (o_ready) begin
      r_valid <= i_up_valid;
    end
  end

  // Slot payload, captured only on an actual transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= RESET_VAL;
    end else if (w_load) begin
      r_data <= i_up_data;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic pipeline of STAGES registered slots with bubble collapse,
// synchronous flush and an occupancy counter.
import pipe_reg_chain_pkg::*;

module pipe_reg_chain #(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               STAGES    = DEF_STAGES,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WIDTH-1:0]                    out_data,
  input  logic                                flush,
  output logic [count_width(STAGES)-1:0]      count
);

  localparam int CW = count_width(STAGES);

  if (STAGES < 1 || WIDTH < 1) begin : g_bad_param
    $error("pipe_reg_chain: STAGES and WIDTH must both be at least 1");
  end

  logic             w_valid   [STAGES];
  logic [WIDTH-1:0] w_data    [STAGES];
  logic             w_ready   [STAGES+1];
  logic             w_up_valid[STAGES];
  logic [WIDTH-1:0] w_up_data [STAGES];
  logic             w_in_acc;
  logic             w_out_acc;
  logic [CW-1:0]    r_count;

  assign w_ready[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_up_valid[k] = in_valid;
      assign w_up_data[k]  = in_data;
    end else begin : g_body
      assign w_up_valid[k] = w_valid[k-1];
      assign w_up_data[k]  = w_data[k-1];
    end

    pipe_reg_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_flush    (flush),
      .i_up_valid (w_up_valid[k]),
      .i_up_data  (w_up_data[k]),
      .i_dn_ready (w_ready[k+1]),
      .o_valid    (w_valid[k]),
      .o_data     (w_data[k]),
      .o_ready    (w_ready[k])
    );
  end

  assign in_ready  = w_ready[0] && !flush;
  assign out_valid = w_valid[STAGES-1];
  assign out_data  = w_data[STAGES-1];
  assign w_in_acc  = in_valid && in_ready;
  assign w_out_acc = out_valid && out_ready;
  assign count     = r_count;

  // Occupancy tracks the valid bits: +1 per accepted beat, -1 per delivered beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {CW{1'b0}};
    end else if (flush) begin
      r_count <= {CW{1'b0}};
    end else begin
      r_count <= r_count + CW'(w_in_acc) - CW'(w_out_acc);
    end
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed plus random checks of pipe_reg_chain against a beat-queue model.
module tb_pipe_reg_chain;

  localparam int WIDTH  = 3;
  localparam int STAGES = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [1:0]       count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Model: beats in flight, oldest first, with the edge number that accepted each.
  logic [WIDTH-1:0] q_data[$];
  int               q_cyc[$];

  pipe_reg_chain #(
    .WIDTH     (WIDTH),
    .STAGES    (STAGES),
    .RESET_VAL (3'b000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Head beat reaches the last stage STAGES-1 edges after acceptance; the
  // oldest beat is never blocked by anything ahead of it.
  function automatic logic model_out_valid();
    return (q_data.size() > 0) && ((cyc - q_cyc[0]) >= STAGES - 1);
  endfunction

  task automatic check_outputs(input string tag);
    logic mv;
    mv = model_out_valid();
    check({tag, "_ovalid"}, 32'(out_valid), 32'(mv));
    check({tag, "_count"}, 32'(count), 32'(q_data.size()));
    if (mv) check({tag, "_odata"}, 32'(out_data), 32'(q_data[0]));
  endtask

  // One clock cycle: apply inputs, check in_ready, clock, update model, check outputs.
  task automatic step(input logic iv, input logic [WIDTH-1:0] id, input logic ordy,
                      input logic fl, input string tag);
    logic exp_rdy;
    logic hs_in;
    logic hs_out;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_rdy = !fl && ((q_data.size() < STAGES) || ordy);
    check({tag, "_iready"}, 32'(in_ready), 32'(exp_rdy));
    hs_out = model_out_valid() && ordy;
    hs_in  = iv && exp_rdy;
    @(posedge clk);
    cyc++;
    if (hs_out) begin
      void'(q_data.pop_front());
      void'(q_cyc.pop_front());
    end
    if (fl) begin
      q_data.delete();
      q_cyc.delete();
    end else if (hs_in) begin
      q_data.push_back(id);
      q_cyc.push_back(cyc);
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 3'b000;
    out_ready = 1'b0;
    flush     = 1'b0;
    #2;
    check("rst_ovalid", 32'(out_valid), 32'd0);
    check("rst_odata", 32'(out_data), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_iready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single beat latency.
    step(1'b1, 3'b111, 1'b1, 1'b0, "lat_push");
    check("lat_e1_ovalid", 32'(out_valid), 32'd0);
    step(1'b0, 3'b000, 1'b1, 1'b0, "lat_e2");
    check("lat_e2_ovalid", 32'(out_valid), 32'd1);
    check("lat_e2_odata", 32'(out_data), 32'h7);
    step(1'b0, 3'b000, 1'b1, 1'b0, "lat_e3");
    check("lat_e3_ovalid", 32'(out_valid), 32'd0);

    // Backpressure fill and ordered drain.
    step(1'b1, 3'b001, 1'b0, 1'b0, "bp_p1");
    step(1'b1, 3'b010, 1'b0, 1'b0, "bp_p2");
    step(1'b1, 3'b011, 1'b0, 1'b0, "bp_p3");
    check("bp_count", 32'(count), 32'd2);
    check("bp_iready", 32'(in_ready), 32'd0);
    check("bp_hold", 32'(out_data), 32'h1);
    step(1'b1, 3'b011, 1'b1, 1'b0, "bp_d1");
    check("bp_d1_odata", 32'(out_data), 32'h2);
    step(1'b0, 3'b000, 1'b1, 1'b0, "bp_d2");
    check("bp_d2_odata", 32'(out_data), 32'h3);
    step(1'b0, 3'b000, 1'b1, 1'b0, "bp_d3");
    step(1'b0, 3'b000, 1'b1, 1'b0, "bp_d4");

    // Back-to-back stream.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i), 1'b1, 1'b0, "str");
      if (i >= 1) check("str_count", 32'(count), 32'd2);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 3'b000, 1'b1, 1'b0, "str_drain");

    // Flush with a full chain and a pending input beat.
    step(1'b1, 3'b101, 1'b0, 1'b0, "fl_p1");
    step(1'b1, 3'b110, 1'b0, 1'b0, "fl_p2");
    check("fl_full", 32'(count), 32'd2);
    step(1'b1, 3'b100, 1'b0, 1'b1, "fl_go");
    check("fl_count", 32'(count), 32'd0);
    check("fl_ovalid", 32'(out_valid), 32'd0);
    step(1'b0, 3'b000, 1'b1, 1'b0, "fl_after");

    // Asynchronous reset in the middle of a stream.
    step(1'b1, 3'b011, 1'b1, 1'b0, "ar_s1");
    step(1'b1, 3'b101, 1'b1, 1'b0, "ar_s2");
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_ovalid", 32'(out_valid), 32'd0);
    check("ar_odata", 32'(out_data), 32'd0);
    check("ar_count", 32'(count), 32'd0);
    check("ar_iready", 32'(in_ready), 32'd1);
    q_data.delete();
    q_cyc.delete();
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    step(1'b1, 3'b010, 1'b1, 1'b0, "ar_first");
    check("ar_first_count", 32'(count), 32'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 3'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 3, data bits per beat (>=1).
REQ-002 SHALL have parameter STAGES, default 2, register stages in chain (>=1).
REQ-003 SHALL have parameter RESET_VAL, default 0, reset value of every data register.
REQ-004 SHALL have port clk  input  1  single clock, all state updated on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream beat present.
REQ-007 SHALL have port in_ready  output  1  chain accepts beat this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream beat.
REQ-009 SHALL have port out_valid  output  1  last stage holds a beat.
REQ-010 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-011 SHALL have port out_data  output  WIDTH  last stage data.
REQ-012 SHALL have port flush  input  1  synchronous discard of all held beats.
REQ-013 SHALL have port count  output  $clog2(STAGES+1)  number of occupied stages.

Function
REQ-014 Each stage k SHALL hold data_k and valid_k; out_valid/out_data SHALL be stage STAGES-1 registers directly.
REQ-015 Stage k ready SHALL be !valid_k || ready_(k+1); ready_(STAGES) = out_ready; in_ready = ready_0 && !flush (combinational).
REQ-016 Transfer into a stage SHALL occur on the rising edge when upstream valid and stage ready are both 1; otherwise stage data and valid SHALL hold.
REQ-017 Latency: with chain empty and out_ready=1, a beat accepted at edge t SHALL appear on out_data with out_valid=1 after edge t+STAGES-1 (STAGES cycles from accept cycle).
REQ-018 Throughput SHALL be one beat per cycle when out_ready=1; beat order SHALL be preserved; no beat duplicated or dropped.
REQ-019 Under backpressure (out_ready=0) out_data SHALL stay stable while out_valid=1; bubbles SHALL collapse so all STAGES fill before in_ready drops.
REQ-020 Full chain with in_valid=1 and out_ready=1 SHALL shift all stages in the same edge; count unchanged.
REQ-021 flush=1 SHALL clear every valid_k at the next edge; an output handshake in the flush cycle SHALL complete normally; no input beat SHALL be accepted in the flush cycle; data registers SHALL NOT be cleared by flush.
REQ-022 count SHALL equal the number of set valid_k bits, updated in the same edge as the valids.

Reset
REQ-023 rst_n=0 SHALL immediately, without a clock edge, clear all valid_k, set all data_k to RESET_VAL, giving out_valid=0, out_data=RESET_VAL, count=0.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight beats; in_ready SHALL be 1 during reset when flush=0.
REQ-025 First accept after rst_n deasserts SHALL be on the first subsequent rising edge with in_valid=1.

Structure
REQ-026 Shared package SHALL hold default WIDTH, STAGES, RESET_VAL constants and the count-width function.
REQ-027 One sub-module pipe_reg_stage (data+valid register with ready logic) SHALL be instantiated STAGES times by a generate loop.
REQ-028 STAGES<1 or WIDTH<1 SHALL cause an elaboration error.

Verification (WIDTH=3, STAGES=2)
REQ-029 rst_n=0 -> out_valid=0, out_data=3'b000, count=0, in_ready=1.
REQ-030 Push 3'b111 at edge 1, out_ready=1 -> out_valid=1, out_data=3'b111 after edge 2, out_valid=0 after edge 3.
REQ-031 out_ready=0, push 3'b001,3'b010,3'b011 -> count=2, in_ready=0, third held; raise out_ready -> outputs 001,010,011 in order on consecutive cycles.
REQ-032 Stream 0..7 back-to-back, out_ready=1 -> out_data 0..7 on consecutive cycles, count=2 throughout steady state.
REQ-033 count=2, flush=1 with in_valid=1 -> in_ready=0, after edge count=0, out_valid=0, beat not accepted.
REQ-034 Drop rst_n between edges mid-stream -> out_valid=0, out_data=3'b000, count=0 before next edge.
